riscv_test_ctrl: RTL and testbench

RISCV_TEST_CTRL -- requirements
Module: riscv_test_ctrl

---
 rtl/riscv_test_ctrl.sv | 167 ++++++++++++++++
 tb/tb_riscv_test_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_test_ctrl.sv
// riscv_test_ctrl: end-of-test controller for a RISC-V core under simulation.
//
// The controller holds the core in reset for RESET_CYCLES clocks and then lets it run.
// While the core runs, it watches the data-memory store port for a full-word write to the
// tohost mailbox. A value of 1 ends the test as PASS. Any other non-zero value ends it as
// FAIL and reports value>>1 as the fail code. If no result arrives within MAX_CYCLES run
// cycles, the test ends as TIMEOUT. Every terminal state is sticky until i_rstn is asserted.
//
// Optional feature: define RISCV_TEST_CTRL_STORE_LOG_EN to count the stores made during RUN
// and to capture the address of the most recent one. When the macro is undefined, both log
// outputs are tied to 0 and no logging registers exist.
//
// Ports:
//   i_clk              clock, rising edge
//   i_rstn             asynchronous active-low reset
//   i_dmem_wr_en       core data-memory write strobe
//   i_dmem_addr        core data-memory address        [XLEN]
//   i_dmem_byte_sel    core write byte enables         [4]
//   i_dmem_wr_data     core write data                 [XLEN]
//   o_core_rstn        active-low reset to the core
//   o_done             test finished (pass, fail or timeout)
//   o_pass/o_fail/o_timeout  result flags, one-hot when o_done=1
//   o_fail_code        tohost value >> 1 on fail       [XLEN]
//   o_cycle_cnt        cycles spent in RUN             [CNT_W]
//   o_store_cnt        stores observed in RUN          [CNT_W]
//   o_last_store_addr  address of the most recent store [XLEN]

module riscv_test_ctrl #(
   parameter int unsigned     XLEN         = 32,
   parameter int unsigned     RESET_CYCLES = 4,
   parameter int unsigned     MAX_CYCLES   = 200,
   parameter logic [XLEN-1:0] TOHOST_ADDR  = XLEN'(32'h0000_1000),
   parameter int unsigned     CNT_W        = 32,
   parameter bit              HALT_ON_DONE = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_dmem_wr_en,
   input  logic [XLEN-1:0]  i_dmem_addr,
   input  logic [3:0]       i_dmem_byte_sel,
   input  logic [XLEN-1:0]  i_dmem_wr_data,
   output logic             o_core_rstn,
   output logic             o_done,
   output logic             o_pass,
   output logic             o_fail,
   output logic             o_timeout,
   output logic [XLEN-1:0]  o_fail_code,
   output logic [CNT_W-1:0] o_cycle_cnt,
   output logic [CNT_W-1:0] o_store_cnt,
   output logic [XLEN-1:0]  o_last_store_addr
);

   typedef enum logic [2:0] {
      StHold,
      StRun,
      StPass,
      StFail,
      StTimeout
   } state_e;

   localparam logic [7:0]       HoldLast     = 8'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] CycLast      = CNT_W'(MAX_CYCLES - 1);
   // Core reset level to drive once the test has ended.
   localparam logic             TermCoreRstn = HALT_ON_DONE ? 1'b0 : 1'b1;

   state_e            state_q;
   logic [7:0]        hold_cnt_q;
   logic              core_rstn_q;
   logic              done_q;
   logic              pass_q;
   logic              fail_q;
   logic              timeout_q;
   logic [XLEN-1:0]   fail_code_q;
   logic [CNT_W-1:0]  cycle_cnt_q;

   logic              tohost_wr;
   logic              data_is_one;
   logic              data_is_zero;

   // Only a full-word store to the mailbox counts as a result. Partial stores are ignored.
   assign tohost_wr    = i_dmem_wr_en && (i_dmem_addr == TOHOST_ADDR) &&
                         (i_dmem_byte_sel == 4'hF);
   assign data_is_one  = (i_dmem_wr_data == XLEN'(1));
   assign data_is_zero = (i_dmem_wr_data == '0);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= StHold;
         hold_cnt_q  <= '0;
         core_rstn_q <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
         fail_code_q <= '0;
         cycle_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StHold: begin
               if (hold_cnt_q == HoldLast) begin
                  state_q     <= StRun;
                  core_rstn_q <= 1'b1;
                  hold_cnt_q  <= '0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 8'd1;
               end
            end
            StRun: begin
               // A tohost result outranks a timeout in the same cycle. On exit the
               // counter is left untouched, so it freezes at the value of the final cycle.
               if (tohost_wr && data_is_one) begin
                  state_q     <= StPass;
                  done_q      <= 1'b1;
                  pass_q      <= 1'b1;
                  core_rstn_q <= TermCoreRstn;
               end else if (tohost_wr && !data_is_zero) begin
                  state_q     <= StFail;
                  done_q      <= 1'b1;
                  fail_q      <= 1'b1;
                  fail_code_q <= i_dmem_wr_data >> 1;
                  core_rstn_q <= TermCoreRstn;
               end else if (cycle_cnt_q == CycLast) begin
                  state_q     <= StTimeout;
                  done_q      <= 1'b1;
                  timeout_q   <= 1'b1;
                  core_rstn_q <= TermCoreRstn;
               end else begin
                  cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
               end
            end
            // Terminal states hold everything until the next reset.
            default: ;
         endcase
      end
   end

   assign o_core_rstn = core_rstn_q;
   assign o_done      = done_q;
   assign o_pass      = pass_q;
   assign o_fail      = fail_q;
   assign o_timeout   = timeout_q;
   assign o_fail_code = fail_code_q;
   assign o_cycle_cnt = cycle_cnt_q;

`ifdef RISCV_TEST_CTRL_STORE_LOG_EN
   logic [CNT_W-1:0] store_cnt_q;
   logic [XLEN-1:0]  last_addr_q;

   // Every store made in RUN is logged, including partial ones and the mailbox write itself.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         store_cnt_q <= '0;
         last_addr_q <= '0;
      end else if ((state_q == StRun) && i_dmem_wr_en) begin
         store_cnt_q <= store_cnt_q + CNT_W'(1);
         last_addr_q <= i_dmem_addr;
      end
   end

   assign o_store_cnt       = store_cnt_q;
   assign o_last_store_addr = last_addr_q;
`else
   assign o_store_cnt       = '0;
   assign o_last_store_addr = '0;
`endif

endmodule

// File: tb/tb_riscv_test_ctrl.sv
// Testbench for riscv_test_ctrl using the default parameters.
// A table of per-cycle vectors exercises the RUN and FAIL behaviour. Hand-written sequences
// then cover PASS at run cycle 50, the timeout boundary, the tohost-over-timeout priority,
// the store log, and an asynchronous reset applied mid-RUN.
module tb_riscv_test_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        wr_en = 1'b0;
   logic [31:0] addr = '0;
   logic [3:0]  bsel = '0;
   logic [31:0] wdata = '0;

   logic        core_rstn, done, pass, fail, tmo;
   logic [31:0] fail_code, cycle_cnt, store_cnt, last_addr;

   int total = 0;
   int bad = 0;

   riscv_test_ctrl dut (
      .i_clk             (clk),
      .i_rstn            (rstn),
      .i_dmem_wr_en      (wr_en),
      .i_dmem_addr       (addr),
      .i_dmem_byte_sel   (bsel),
      .i_dmem_wr_data    (wdata),
      .o_core_rstn       (core_rstn),
      .o_done            (done),
      .o_pass            (pass),
      .o_fail            (fail),
      .o_timeout         (tmo),
      .o_fail_code       (fail_code),
      .o_cycle_cnt       (cycle_cnt),
      .o_store_cnt       (store_cnt),
      .o_last_store_addr (last_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr_en;
      logic [31:0] addr;
      logic [3:0]  bsel;
      logic [31:0] data;
      logic        done;
      logic        pass;
      logic        fail;
      logic        tmo;
      logic        core;
      logic [31:0] code;
      logic [31:0] cyc;
      logic [31:0] scnt;
      logic [31:0] saddr;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected store-log value: the log reads 0 when the feature is compiled out.
   function automatic logic [31:0] slog(input logic [31:0] v);
`ifdef RISCV_TEST_CTRL_STORE_LOG_EN
      return v;
`else
      return 32'h0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic [31:0] a, input logic [3:0] bs,
                        input logic [31:0] d);
      wr_en = en;
      addr  = a;
      bsel  = bs;
      wdata = d;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 32'h0, 4'h0, 32'h0);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Applies reset, releases it, and checks the 4-cycle hold sequence into RUN cycle 0.
   task automatic do_reset();
      drive(1'b0, 32'h0, 4'h0, 32'h0);
      rstn = 1'b0;
      tick();
      tick();
      check("rst_core_rstn", core_rstn, 0);
      check("rst_done", done, 0);
      check("rst_flags", {pass, fail, tmo}, 0);
      check("rst_fail_code", fail_code, 0);
      check("rst_cycle_cnt", cycle_cnt, 0);
      check("rst_store_cnt", store_cnt, 0);
      check("rst_last_addr", last_addr, 0);
      rstn = 1'b1;
      check("hold_core_rstn_c0", core_rstn, 0);
      for (int i = 1; i < 4; i++) begin
         tick();
         check($sformatf("hold_core_rstn_c%0d", i), core_rstn, 0);
      end
      tick();
      check("run_core_rstn", core_rstn, 1);
      check("run_cycle_cnt0", cycle_cnt, 0);
      check("run_done0", done, 0);
   endtask

   initial begin
      // Run starts at cycle_cnt=0 and each vector is applied for one cycle.
      // Expected values are the outputs seen after that cycle's rising edge.
      vecs[0] = '{1'b1, 32'h1000, 4'h1, 32'h1, 0, 0, 0, 0, 1, 32'h0, 32'd1, 32'd1, 32'h1000};
      vecs[1] = '{1'b1, 32'h1000, 4'hF, 32'h0, 0, 0, 0, 0, 1, 32'h0, 32'd2, 32'd2, 32'h1000};
      vecs[2] = '{1'b1, 32'h0020, 4'hF, 32'h1, 0, 0, 0, 0, 1, 32'h0, 32'd3, 32'd3, 32'h0020};
      vecs[3] = '{1'b1, 32'h0024, 4'hF, 32'h5, 0, 0, 0, 0, 1, 32'h0, 32'd4, 32'd4, 32'h0024};
      vecs[4] = '{1'b0, 32'h1000, 4'hF, 32'h1, 0, 0, 0, 0, 1, 32'h0, 32'd5, 32'd4, 32'h0024};
      vecs[5] = '{1'b1, 32'h1000, 4'hF, 32'h7, 1, 0, 1, 0, 0, 32'h3, 32'd5, 32'd5, 32'h1000};
      vecs[6] = '{1'b1, 32'h1000, 4'hF, 32'h1, 1, 0, 1, 0, 0, 32'h3, 32'd5, 32'd5, 32'h1000};
      vecs[7] = '{1'b0, 32'h0000, 4'h0, 32'h0, 1, 0, 1, 0, 0, 32'h3, 32'd5, 32'd5, 32'h1000};

      #2;
      do_reset();

      for (int v = 0; v < 8; v++) begin
         drive(vecs[v].wr_en, vecs[v].addr, vecs[v].bsel, vecs[v].data);
         tick();
         check($sformatf("v%0d_done", v), done, vecs[v].done);
         check($sformatf("v%0d_pass", v), pass, vecs[v].pass);
         check($sformatf("v%0d_fail", v), fail, vecs[v].fail);
         check($sformatf("v%0d_timeout", v), tmo, vecs[v].tmo);
         check($sformatf("v%0d_core_rstn", v), core_rstn, vecs[v].core);
         check($sformatf("v%0d_fail_code", v), fail_code, vecs[v].code);
         check($sformatf("v%0d_cycle_cnt", v), cycle_cnt, vecs[v].cyc);
         check($sformatf("v%0d_store_cnt", v), store_cnt, slog(vecs[v].scnt));
         check($sformatf("v%0d_last_addr", v), last_addr, slog(vecs[v].saddr));
      end

      // PASS at run cycle 50.
      do_reset();
      idle(50);
      check("p50_cnt_before", cycle_cnt, 50);
      check("p50_done_before", done, 0);
      drive(1'b1, 32'h1000, 4'hF, 32'h1);
      tick();
      check("p50_pass", pass, 1);
      check("p50_done", done, 1);
      check("p50_fail_tmo", {fail, tmo}, 0);
      check("p50_cycle_cnt", cycle_cnt, 50);
      check("p50_core_rstn", core_rstn, 0);
      check("p50_store_cnt", store_cnt, slog(32'd1));
      idle(3);
      check("p50_sticky", {done, pass, fail, tmo}, 4'b1100);
      check("p50_frozen", cycle_cnt, 50);

      // Timeout after run cycle 199.
      do_reset();
      idle(199);
      check("to_cnt199", cycle_cnt, 199);
      check("to_not_done", done, 0);
      tick();
      check("to_timeout", tmo, 1);
      check("to_done", done, 1);
      check("to_pass_fail", {pass, fail}, 0);
      check("to_cycle_cnt", cycle_cnt, 199);
      check("to_core_rstn", core_rstn, 0);
      drive(1'b1, 32'h1000, 4'hF, 32'h1);
      tick();
      check("to_sticky", {done, pass, fail, tmo}, 4'b1001);
      check("to_frozen", cycle_cnt, 199);

      // A tohost pass in cycle 199 outranks the timeout.
      do_reset();
      idle(199);
      drive(1'b1, 32'h1000, 4'hF, 32'h1);
      tick();
      check("prio_pass", pass, 1);
      check("prio_timeout", tmo, 0);
      check("prio_cycle_cnt", cycle_cnt, 199);

      // Store log: 0x20, 0x24, then the mailbox.
      do_reset();
      drive(1'b1, 32'h0020, 4'hF, 32'hAA);
      tick();
      drive(1'b1, 32'h0024, 4'h3, 32'hBB);
      tick();
      drive(1'b1, 32'h1000, 4'hF, 32'h1);
      tick();
      check("log_store_cnt", store_cnt, slog(32'd3));
      check("log_last_addr", last_addr, slog(32'h1000));
      check("log_pass", pass, 1);
      check("log_cycle_cnt", cycle_cnt, 2);

      // Asynchronous reset mid-RUN clears the outputs without waiting for a clock edge.
      do_reset();
      drive(1'b1, 32'h0040, 4'hF, 32'h9);
      tick();
      idle(9);
      check("mid_cnt10", cycle_cnt, 10);
      #2;
      rstn = 1'b0;
      #1;
      check("mid_async_cycle_cnt", cycle_cnt, 0);
      check("mid_async_core_rstn", core_rstn, 0);
      check("mid_async_store_cnt", store_cnt, 0);
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
